mrv1_imem_responder: RTL and testbench
======================================

// Module: mrv1_imem_responder
// PURPOSE
//  Responder end of the IFETCH<->IMEM interface: accepts tagged fetch requests, reads a local
//  instruction SRAM, returns data and tag after a fixed pipelined latency. No response
//  backpressure exists on this interface, so every accepted request produces exactly one response.
//  Sits between the mtcore fetch unit and a host/loader that preloads program images.
// PARAMETERS
//  IMEM_TAG_WIDTH_P  3     width of request/response tag (fetch unit passes TID)
//  MEM_WORDS_P       1024  32-bit words in SRAM; power of two
//  LATENCY_P         2     accept-to-response cycles; legal range 1..8
//  MEM_AW_LP         $clog2(MEM_WORDS_P) word-index width (derived)
// PORTS
//  clk_i             in   1      clock
//  rst_ni            in   1      reset, asynchronous, active-low
//  imem_req_vld_i    in   1      fetch request valid
//  imem_req_rdy_o    out  1      request accepted when vld&rdy at posedge
//  imem_req_addr_i   in   32     byte address
//  imem_req_tag_i    in   TAG    request tag
//  imem_resp_vld_o   out  1      response valid (single-cycle pulse per request)
//  imem_resp_tag_o   out  TAG    tag of the request being answered
//  imem_resp_data_o  out  32     instruction word
//  imem_resp_err_o   out  1      qualifies resp: misaligned or out-of-range address
//  stall_i           in   1      external throttle; forces req_rdy_o low
//  ld_vld_i          in   1      loader write strobe
//  ld_addr_i         in   MEM_AW word index for loader write
//  ld_data_i         in   32     loader write data
//  outstanding_o     out  4      requests accepted but not yet responded
// BEHAVIOUR
//  - Reset (rst_ni low, async): all pipeline valids cleared; resp_vld/err/tag/data=0;
//    outstanding_o=0; req_rdy_o=0 while in reset. SRAM contents are not reset.
//  - req_rdy_o = rst_ni & ~stall_i & ~ld_vld_i (combinational; loader has priority).
//  - Accept in cycle N => SRAM read at that edge; response on resp_* throughout cycle N+LATENCY_P.
//    Fully pipelined: back-to-back accepts give back-to-back responses, strictly in order.
//  - Pipeline: LATENCY_P stages of {vld, tag, err}; stage 1 captures SRAM read data, later stages
//    shift it. A stage is a bubble (vld=0) when no accept occurred; bubbles never compress.
//  - Word index = addr[MEM_AW_LP+1:2]. err=1 if addr[1:0]!=0 or addr[31:MEM_AW_LP+2]!=0;
//    on err data = ILLEGAL_INSN (32'h0000_0000); the SRAM is still indexed but its data is discarded.
//  - resp_data_o/tag_o/err_o hold the last-stage values; they are don't-care when resp_vld_o=0
//    and are driven to 0 on bubbles.
//  - Loader write: ld_vld_i writes ld_data_i at posedge, no request accepted that cycle.
//    A request accepted before the write returns old data (read-before-write by ordering).
//    A request accepted the cycle after the write sees the new data.
//  - outstanding_o: +1 on accept, -1 on resp_vld_o; simultaneous => unchanged. Max = LATENCY_P.
//  - Reset mid-flight: in-flight responses are dropped; none emerge after reset release.
//  - stall_i/ld_vld_i never affect in-flight requests; the pipeline always advances.
// STRUCTURE
//  - mrv1_imem_pkg: ILLEGAL_INSN constant; imem_pipe_t struct {vld, tag, err, data} using
//    tag-width parameter via parameterised typedef in module; LATENCY_MAX=8.
//  - Sub-module mrv1_imem_sram: 1R1W synchronous array, MEM_WORDS_P x 32, registered read
//    output, write port separate; no reset on storage.
//  - Top: ready logic, address check, LATENCY_P-deep shift pipeline, outstanding counter.
// TESTING
//  1 Load word 5 = 32'h0000_0013 via loader; req addr 0x14 tag 3 at cycle N, LATENCY_P=2
//    -> resp_vld in cycle N+2, tag=3, data=0x13, err=0; outstanding 1,1,0.
//  2 Four back-to-back reqs addr 0x0,0x4,0x8,0xC tags 0..3 -> four consecutive responses in order
//    with matching tags/data; outstanding peaks at 2.
//  3 Req addr 0x2 and req addr 0x1000 (MEM_WORDS_P=1024) -> err=1, data=0 for both, tag preserved.
//  4 ld_vld_i and req_vld_i same cycle -> req_rdy_o=0, request retried next cycle sees new data;
//    stall_i high 3 cycles -> no accepts, in-flight response still delivered on time.
//  5 Accept 2 reqs then pulse rst_ni low mid-flight -> no resp_vld_o after release,
//    outstanding_o=0, req_rdy_o=0 during reset.
//  6 Random vld/stall/loader traffic against a scoreboard model, LATENCY_P in {1,2,5}
//    -> every accepted tag answered exactly once, in order, at fixed latency.

Source files
------------

// File: rtl/mrv1_imem_pkg.sv
// Shared constants and helpers for the IMEM responder slice.
package mrv1_imem_pkg;

  localparam int          IMEM_DW      = 32;
  localparam int          LATENCY_MAX  = 8;
  localparam logic [31:0] ILLEGAL_INSN = 32'h0000_0000;

  // Misaligned byte address, or any address bit above the SRAM word range set.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    addr_err = (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mrv1_imem_sram.sv
// 1R1W synchronous instruction array with registered read data; storage is never reset.
module mrv1_imem_sram
  import mrv1_imem_pkg::*;
#(
  parameter  int WORDS_P = 1024,
  localparam int AW_LP   = $clog2(WORDS_P)
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [AW_LP-1:0]   rd_addr,
  output logic [IMEM_DW-1:0] rd_data,
  input  logic               wr_en,
  input  logic [AW_LP-1:0]   wr_addr,
  input  logic [IMEM_DW-1:0] wr_data
);

  logic [IMEM_DW-1:0] mem [WORDS_P];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mrv1_imem_responder.sv
// IMEM responder: accepts tagged fetches, reads the local SRAM and answers in order
// after a fixed LATENCY_P cycles with no backpressure on the response side.
module mrv1_imem_responder
  import mrv1_imem_pkg::*;
#(
  parameter  int IMEM_TAG_WIDTH_P = 3,
  parameter  int MEM_WORDS_P      = 1024,
  parameter  int LATENCY_P        = 2,
  localparam int MEM_AW_LP        = $clog2(MEM_WORDS_P)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        imem_req_vld_i,
  output logic                        imem_req_rdy_o,
  input  logic [31:0]                 imem_req_addr_i,
  input  logic [IMEM_TAG_WIDTH_P-1:0] imem_req_tag_i,
  output logic                        imem_resp_vld_o,
  output logic [IMEM_TAG_WIDTH_P-1:0] imem_resp_tag_o,
  output logic [31:0]                 imem_resp_data_o,
  output logic                        imem_resp_err_o,
  input  logic                        stall_i,
  input  logic                        ld_vld_i,
  input  logic [MEM_AW_LP-1:0]        ld_addr_i,
  input  logic [31:0]                 ld_data_i,
  output logic [3:0]                  outstanding_o
);

  typedef struct packed {
    logic                        vld;
    logic [IMEM_TAG_WIDTH_P-1:0] tag;
    logic                        err;
    logic [IMEM_DW-1:0]          data;
  } imem_pipe_t;

  logic                 accept;
  logic                 req_err;
  logic [MEM_AW_LP-1:0] word_idx;
  logic [IMEM_DW-1:0]   sram_data;

  imem_pipe_t stage_q [LATENCY_P];
  imem_pipe_t stage   [LATENCY_P];

  // Loader owns the array for the cycle it writes, so requests are held off.
  assign imem_req_rdy_o = rst_ni & ~stall_i & ~ld_vld_i;
  assign accept         = imem_req_vld_i & imem_req_rdy_o;
  assign word_idx       = imem_req_addr_i[MEM_AW_LP+1:2];
  assign req_err        = addr_err(imem_req_addr_i, MEM_AW_LP);

  mrv1_imem_sram #(
    .WORDS_P (MEM_WORDS_P)
  ) u_sram (
    .clk     (clk_i),
    .rd_en   (accept),
    .rd_addr (word_idx),
    .rd_data (sram_data),
    .wr_en   (ld_vld_i),
    .wr_addr (ld_addr_i),
    .wr_data (ld_data_i)
  );

  // Stage 0 data lives in the SRAM read register; it is merged in here so later
  // stages shift a complete record.
  always_comb begin
    stage = stage_q;
    if (!stage_q[0].vld)     stage[0].data = '0;
    else if (stage_q[0].err) stage[0].data = ILLEGAL_INSN;
    else                     stage[0].data = sram_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY_P; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{vld:  accept,
                      tag:  accept ? imem_req_tag_i : '0,
                      err:  accept & req_err,
                      data: '0};
      for (int i = 1; i < LATENCY_P; i++) stage_q[i] <= stage[i-1];
    end
  end

  assign imem_resp_vld_o  = stage[LATENCY_P-1].vld;
  assign imem_resp_tag_o  = stage[LATENCY_P-1].tag;
  assign imem_resp_err_o  = stage[LATENCY_P-1].err;
  assign imem_resp_data_o = stage[LATENCY_P-1].data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
    end else begin
      case ({accept, imem_resp_vld_o})
        2'b10:   outstanding_o <= outstanding_o + 4'd1;
        2'b01:   outstanding_o <= outstanding_o - 4'd1;
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

endmodule

// File: tb/tb_mrv1_imem_responder.sv
// Directed and random checks of three responder instances (latency 2, 1, 5) sharing stimulus.
module tb_mrv1_imem_responder;

  localparam int ND = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld;
  logic [31:0] req_addr;
  logic [2:0]  req_tag;
  logic        stall;
  logic        ld_vld;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        rdy       [ND];
  logic        resp_vld  [ND];
  logic        resp_err  [ND];
  logic [2:0]  resp_tag  [ND];
  logic [31:0] resp_data [ND];
  logic [3:0]  outst     [ND];

  typedef struct {
    int          acc;
    logic [2:0]  tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  int          head [ND];
  logic [31:0] mem_model [16];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  int          peak;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mrv1_imem_responder #(.LATENCY_P(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .imem_req_vld_i(req_vld), .imem_req_rdy_o(rdy[0]),
    .imem_req_addr_i(req_addr), .imem_req_tag_i(req_tag), .imem_resp_vld_o(resp_vld[0]),
    .imem_resp_tag_o(resp_tag[0]), .imem_resp_data_o(resp_data[0]), .imem_resp_err_o(resp_err[0]),
    .stall_i(stall), .ld_vld_i(ld_vld), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .outstanding_o(outst[0]));

  mrv1_imem_responder #(.LATENCY_P(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .imem_req_vld_i(req_vld), .imem_req_rdy_o(rdy[1]),
    .imem_req_addr_i(req_addr), .imem_req_tag_i(req_tag), .imem_resp_vld_o(resp_vld[1]),
    .imem_resp_tag_o(resp_tag[1]), .imem_resp_data_o(resp_data[1]), .imem_resp_err_o(resp_err[1]),
    .stall_i(stall), .ld_vld_i(ld_vld), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .outstanding_o(outst[1]));

  mrv1_imem_responder #(.LATENCY_P(5)) u_l5 (
    .clk_i(clk), .rst_ni(rst_n), .imem_req_vld_i(req_vld), .imem_req_rdy_o(rdy[2]),
    .imem_req_addr_i(req_addr), .imem_req_tag_i(req_tag), .imem_resp_vld_o(resp_vld[2]),
    .imem_resp_tag_o(resp_tag[2]), .imem_resp_data_o(resp_data[2]), .imem_resp_err_o(resp_err[2]),
    .stall_i(stall), .ld_vld_i(ld_vld), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .outstanding_o(outst[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      string p;
      p = $sformatf("L%0d", lat_of(d));
      chk({p, "_rdy"}, 64'(rdy[d]), 64'(rst_n & ~stall & ~ld_vld));
      chk({p, "_outstanding"}, 64'(outst[d]), 64'(sb.size() - head[d]));
      if (head[d] < sb.size() && sb[head[d]].acc + lat_of(d) - 1 == cyc) begin
        chk({p, "_vld"},  64'(resp_vld[d]),  64'(1));
        chk({p, "_tag"},  64'(resp_tag[d]),  64'(sb[head[d]].tag));
        chk({p, "_data"}, 64'(resp_data[d]), 64'(sb[head[d]].data));
        chk({p, "_err"},  64'(resp_err[d]),  64'(sb[head[d]].err));
        head[d]++;
      end else begin
        chk({p, "_bubble_vld"},  64'(resp_vld[d]),  64'(0));
        chk({p, "_bubble_tag"},  64'(resp_tag[d]),  64'(0));
        chk({p, "_bubble_data"}, 64'(resp_data[d]), 64'(0));
        chk({p, "_bubble_err"},  64'(resp_err[d]),  64'(0));
      end
    end
  endtask

  // Drive one cycle of inputs, log any accept it causes, then check after the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [2:0] t,
                      input logic s, input logic l, input logic [9:0] la, input logic [31:0] ldd);
    exp_t x;
    req_vld = v; req_addr = a; req_tag = t; stall = s;
    ld_vld = l; ld_addr = la; ld_data = ldd;
    if (v && !s && !l && rst_n) begin
      x.acc  = cyc + 1;
      x.tag  = t;
      x.err  = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
      x.data = x.err ? 32'h0 : mem_model[a[5:2]];
      sb.push_back(x);
    end
    if (l) mem_model[la[3:0]] = ldd;
    @(negedge clk);
    if (outst[0] > 4'(peak)) peak = int'(outst[0]);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 10'd0, 32'h0);
  endtask

  task automatic load(input logic [9:0] la, input logic [31:0] d);
    step(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, la, d);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int r;
      int w;
      r = int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 15));
      a = 32'(w) << 2;
      if (r == 6) a = a + 32'($urandom_range(1, 3));
      if (r == 7) a = a | (($urandom_range(0, 1) != 0) ? 32'h0000_1000 : 32'h8000_0000);
      step($urandom_range(0, 3) != 0, a, 3'($urandom_range(0, 7)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
           10'($urandom_range(0, 15)), $urandom());
    end
  endtask

  // Reset asserted between edges while requests are still in the pipes.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) head[d] = sb.size();
    check_all();
    step(1'b1, 32'h4, 3'd7, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b1, 32'h8, 3'd6, 1'b0, 1'b0, 10'd0, 32'h0);
    chk("t5_rdy_in_reset", 64'(rdy[0]), 64'(0));
    req_vld = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    req_vld = 1'b0; req_addr = '0; req_tag = '0; stall = 1'b0;
    ld_vld = 1'b0; ld_addr = '0; ld_data = '0;
    for (int d = 0; d < ND; d++) head[d] = 0;
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
    peak = 0;

    @(negedge clk);
    check_all();
    step(1'b1, 32'h0, 3'd1, 1'b0, 1'b0, 10'd0, 32'h0);
    chk("reset_rdy", 64'(rdy[0]), 64'(0));
    chk("reset_outstanding", 64'(outst[0]), 64'(0));
    req_vld = 1'b0;
    rst_n   = 1'b1;

    for (int i = 0; i < 16; i++) load(10'(i), 32'hA000_0000 + 32'(i) * 32'h0101);

    // Test 1: single fetch of word 5
    load(10'd5, 32'h0000_0013);
    step(1'b1, 32'h14, 3'd3, 1'b0, 1'b0, 10'd0, 32'h0);
    chk("t1_out_accept", 64'(outst[0]), 64'(1));
    chk("t1_vld_early", 64'(resp_vld[0]), 64'(0));
    idle(1);
    chk("t1_vld", 64'(resp_vld[0]), 64'(1));
    chk("t1_tag", 64'(resp_tag[0]), 64'(3));
    chk("t1_data", 64'(resp_data[0]), 64'(32'h13));
    chk("t1_err", 64'(resp_err[0]), 64'(0));
    chk("t1_out_resp", 64'(outst[0]), 64'(1));
    idle(1);
    chk("t1_out_done", 64'(outst[0]), 64'(0));

    // Test 2: four back-to-back fetches
    peak = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i) << 2, 3'(i), 1'b0, 1'b0, 10'd0, 32'h0);
    chk("t2_first_data", 64'(resp_data[0]), 64'(32'hA000_0202));
    idle(3);
    chk("t2_peak", 64'(peak), 64'(2));

    // Test 3: misaligned and out-of-range addresses
    step(1'b1, 32'h2, 3'd5, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b1, 32'h1000, 3'd6, 1'b0, 1'b0, 10'd0, 32'h0);
    chk("t3_mis_err", 64'(resp_err[0]), 64'(1));
    chk("t3_mis_tag", 64'(resp_tag[0]), 64'(5));
    chk("t3_mis_data", 64'(resp_data[0]), 64'(0));
    idle(1);
    chk("t3_oor_err", 64'(resp_err[0]), 64'(1));
    chk("t3_oor_tag", 64'(resp_tag[0]), 64'(6));
    idle(4);

    // Test 4: loader collision, then stall window with a fetch in flight
    step(1'b1, 32'h18, 3'd1, 1'b0, 1'b1, 10'd6, 32'hDEAD_BEEF);
    chk("t4_rdy_ld", 64'(rdy[0]), 64'(0));
    step(1'b1, 32'h18, 3'd1, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(1);
    chk("t4_new_data", 64'(resp_data[0]), 64'(32'hDEAD_BEEF));
    idle(4);
    step(1'b1, 32'h0, 3'd2, 1'b0, 1'b0, 10'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h4, 3'd4, 1'b1, 1'b0, 10'd0, 32'h0);
      chk("t4_rdy_stall", 64'(rdy[0]), 64'(0));
    end
    chk("t4_out_after_stall", 64'(outst[0]), 64'(0));
    idle(4);

    // Test 5: reset with fetches in flight
    step(1'b1, 32'h8, 3'd2, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b1, 32'hC, 3'd3, 1'b0, 1'b0, 10'd0, 32'h0);
    mid_reset();
    idle(6);
    chk("t5_out_after", 64'(outst[2]), 64'(0));

    // Test 6: random traffic with one reset in the middle
    rand_cycles(300);
    mid_reset();
    rand_cycles(300);
    idle(8);
    for (int d = 0; d < ND; d++)
      chk($sformatf("L%0d_drained", lat_of(d)), 64'(head[d]), 64'(sb.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
